dual_port_mem: RTL and testbench

Parametrised dual-port synchronous RAM: one instruction fetch port (read-only) and one data port (read/write), both with one-cycle read latency. Replaces the fixed 256×16 bidirectional-bus memory with separate read/write data, explicit valid/error handshakes, bounds checking and a post-reset clear sequence. Sits between the CPU fetch/load-store units and on-chip storage.

---
 rtl/mem_pkg.sv | 19 +
 rtl/dual_port_mem_if.sv | 55 +++++
 rtl/mem_init_ctrl.sv | 67 ++++++
 rtl/dual_port_mem.sv | 149 ++++++++++++++
 tb/tb_dual_port_mem.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the dual_port_mem block.
//   mem_state_e : init controller states (clear sweep, normal operation)
//   lane_count  : number of 8-bit byte lanes in a data word
// No ports.
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } mem_state_e;

    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dual_port_mem_if.sv
// ---------------------------------------------------------------------------
// dual_port_mem_if
// Bus bundle between CPU fetch / load-store units and dual_port_mem.
//   master : drives i_req/i_addr and d_req/d_we/d_addr/d_wdata (+ d_be)
//   slave  : drives ready, i_valid/i_rdata/i_err, d_valid/d_rdata/d_err
// Macro MEMORY_BYTE_WRITE_EN adds the d_be byte-lane write enable.
// ---------------------------------------------------------------------------
interface dual_port_mem_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned LANES = lane_count(DATA_W);

    logic              ready;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_valid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
`ifdef MEMORY_BYTE_WRITE_EN
    logic [LANES-1:0]  d_be;
`endif
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

`ifdef MEMORY_BYTE_WRITE_EN
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  ready, i_valid, i_rdata, i_err, d_valid, d_rdata, d_err
    );
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output ready, i_valid, i_rdata, i_err, d_valid, d_rdata, d_err
    );
`else
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  ready, i_valid, i_rdata, i_err, d_valid, d_rdata, d_err
    );
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output ready, i_valid, i_rdata, i_err, d_valid, d_rdata, d_err
    );
`endif

endinterface

// File: rtl/mem_init_ctrl.sv
// ---------------------------------------------------------------------------
// mem_init_ctrl
// Post-reset clear sequencer: sweeps every word index once, then enters run.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   o_ready     : high in run state (requests may be accepted)
//   o_clr_we    : high while the clear sweep owns the storage write port
//   o_clr_idx   : word index being cleared this cycle
// ---------------------------------------------------------------------------
module mem_init_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             o_ready,
    output logic             o_clr_we,
    output logic [IDX_W-1:0] o_clr_idx
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    mem_state_e       r_state;
    mem_state_e       w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StClear;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        unique case (r_state)
            StClear: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = StRun;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            StRun: begin
                w_state_next = StRun;
            end
            default: begin
                w_state_next = StClear;
                w_idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_ready   = (r_state == StRun);
        o_clr_we  = (r_state == StClear);
        o_clr_idx = r_idx;
    end

endmodule

// File: rtl/dual_port_mem.sv
// ---------------------------------------------------------------------------
// dual_port_mem
// Dual-port synchronous RAM: read-only instruction port and read/write data
// port, each with one-cycle read latency, valid/err strobes and bounds check.
// Storage is cleared to INIT_VAL after every reset before ready rises.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dual_port_mem_if.slave (ready, i_* fetch port, d_* data port)
// Macro MEMORY_BYTE_WRITE_EN enables per-byte-lane writes through d_be.
// ---------------------------------------------------------------------------
module dual_port_mem
    import mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    dual_port_mem_if.slave bus
);
    localparam int unsigned     LANES   = lane_count(DATA_W);
    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic              w_clr_we;
    logic [IDX_W-1:0]  w_clr_idx;

    logic              w_i_acc;
    logic              w_d_acc;
    logic              w_i_inr;
    logic              w_d_inr;
    logic [IDX_W-1:0]  w_i_idx;
    logic [IDX_W-1:0]  w_d_idx;
    logic [LANES-1:0]  w_be;
    logic              w_d_wr;
    logic [DATA_W-1:0] w_i_fwd;

    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [LANES-1:0]  w_wbe;

    logic              r_i_valid;
    logic              r_i_err;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_d_valid;
    logic              r_d_err;
    logic [DATA_W-1:0] r_d_rdata;

    mem_init_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_ready   (w_ready),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx)
    );

`ifdef MEMORY_BYTE_WRITE_EN
    assign w_be = bus.d_be;
`else
    assign w_be = '1;
`endif

    // Requests are only accepted in run state; during the clear they vanish.
    assign w_i_acc = w_ready & bus.i_req;
    assign w_d_acc = w_ready & bus.d_req;
    assign w_i_inr = ({1'b0, bus.i_addr} < DEPTH_X);
    assign w_d_inr = ({1'b0, bus.d_addr} < DEPTH_X);
    assign w_i_idx = bus.i_addr[IDX_W-1:0];
    assign w_d_idx = bus.d_addr[IDX_W-1:0];
    assign w_d_wr  = w_d_acc & bus.d_we & w_d_inr;

    // Storage write port: the clear sweep has priority (d_req is ignored then).
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_d_idx;
        w_wdata = bus.d_wdata;
        w_wbe   = w_be;
        if (w_clr_we) begin
            w_we    = rst_n;
            w_waddr = w_clr_idx;
            w_wdata = INIT_VAL;
            w_wbe   = '1;
        end else begin
            w_we = w_d_wr & rst_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_we && w_wbe[k]) begin
                r_mem[w_waddr][8*k +: 8] <= w_wdata[8*k +: 8];
            end
        end
    end

    // Fetch of a word being written this cycle sees the new lanes.
    always_comb begin
        w_i_fwd = r_mem[w_i_idx];
        if (w_d_wr && (w_d_idx == w_i_idx)) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_be[k]) begin
                    w_i_fwd[8*k +: 8] = bus.d_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_valid <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;
        end else begin
            r_i_valid <= w_i_acc;
            r_i_err   <= w_i_acc & ~w_i_inr;
            if (w_i_acc) begin
                r_i_rdata <= w_i_inr ? w_i_fwd : '0;
            end
            r_d_valid <= w_d_acc;
            r_d_err   <= w_d_acc & ~w_d_inr;
            // Writes leave d_rdata holding the last read.
            if (w_d_acc && !bus.d_we) begin
                r_d_rdata <= w_d_inr ? r_mem[w_d_idx] : '0;
            end
        end
    end

    assign bus.ready   = w_ready;
    assign bus.i_valid = r_i_valid;
    assign bus.i_err   = r_i_err;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_valid = r_d_valid;
    assign bus.d_err   = r_d_err;
    assign bus.d_rdata = r_d_rdata;

endmodule

// File: tb/tb_dual_port_mem.sv
// ---------------------------------------------------------------------------
// tb_dual_port_mem
// Scoreboard bench for dual_port_mem: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a response is due.
// Honours MEMORY_BYTE_WRITE_EN when defined.
// ---------------------------------------------------------------------------
module tb_dual_port_mem;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned IW    = 8;
    localparam int unsigned LANES = DW / 8;
    localparam logic [DW-1:0] INIT = 16'h0000;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_port_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dual_port_mem #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t          i_q[$];
    exp_t          d_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            hi_edges = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] d_hold;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) hi_edges <= 0;
        else        hi_edges <= hi_edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [LANES-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < LANES; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // Monitor: every cycle, a response is either due (and must be present) or must be absent.
    always @(negedge clk) begin
        exp_t e;
        check("ready", {31'b0, bus.ready}, {31'b0, hi_edges >= DEPTH});
        if (i_q.size() > 0 && i_q[0].due == cyc) begin
            e = i_q.pop_front();
            check("i_valid", {31'b0, bus.i_valid}, 32'd1);
            check("i_rdata", {16'b0, bus.i_rdata}, {16'b0, e.data});
            check("i_err", {31'b0, bus.i_err}, {31'b0, e.err});
        end else begin
            check("i_valid idle", {31'b0, bus.i_valid}, 32'd0);
        end
        if (d_q.size() > 0 && d_q[0].due == cyc) begin
            e = d_q.pop_front();
            check("d_valid", {31'b0, bus.d_valid}, 32'd1);
            check("d_rdata", {16'b0, bus.d_rdata}, {16'b0, e.data});
            check("d_err", {31'b0, bus.d_err}, {31'b0, e.err});
        end else begin
            check("d_valid idle", {31'b0, bus.d_valid}, 32'd0);
        end
    end

    // Drive one cycle of requests; if the memory will accept them, record expectations.
    task automatic issue(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         input logic [LANES-1:0] be);
        logic [LANES-1:0] eff_be;
        logic [DW-1:0]    val;
        logic             iin;
        logic             din;
        exp_t             e;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = wd;
`ifdef MEMORY_BYTE_WRITE_EN
        bus.d_be = be;
        eff_be   = be;
`else
        eff_be = '1;
`endif
        if (rst_n && hi_edges >= DEPTH) begin
            iin = (ia < DEPTH);
            din = (da < DEPTH);
            if (ir) begin
                val = iin ? model[ia[IW-1:0]] : '0;
                if (dr && dw && din && da == ia) val = merge(val, wd, eff_be);
                e.due = cyc + 1; e.data = val; e.err = !iin;
                i_q.push_back(e);
            end
            if (dr) begin
                if (dw) begin
                    if (din) model[da[IW-1:0]] = merge(model[da[IW-1:0]], wd, eff_be);
                end else begin
                    d_hold = din ? model[da[IW-1:0]] : '0;
                end
                e.due = cyc + 1; e.data = d_hold; e.err = !din;
                d_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) model[a] = INIT;
        d_hold = '0;
    endtask

    // Spin until ready, issuing fetch/read requests that must all be ignored.
    task automatic clear_with_requests();
        for (int n = 0; n < 4 * DEPTH && hi_edges < DEPTH; n++)
            issue(1'b1, 16'h00FF, 1'b1, 1'b0, 16'h00FF, '0, '0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return AW'(DEPTH + $urandom_range(0, 15));
        if (r == 1) return 16'hFFFF;
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0;
`ifdef MEMORY_BYTE_WRITE_EN
        bus.d_be = '0;
`endif
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clear sequence, then first read of 0x00FF returns the cleared value.
        clear_with_requests();
        issue(1'b0, '0, 1'b1, 1'b0, 16'h00FF, '0, '1);

        // Write then read on both ports next cycle.
        issue(1'b0, '0, 1'b1, 1'b1, 16'h000F, 16'hAAAA, '1);
        issue(1'b1, 16'h000F, 1'b1, 1'b0, 16'h000F, '0, '1);
        idle();

        // Same-cycle write/fetch collision.
        issue(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0005, 16'h1234, '1);
        issue(1'b0, '0, 1'b1, 1'b0, 16'h0005, '0, '1);

        // Out-of-range read and write, then confirm word 0 untouched.
        issue(1'b0, '0, 1'b1, 1'b1, 16'h0000, 16'h5A5A, '1);
        issue(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0100, '0, '1);
        issue(1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0100, 16'hDEAD, '1);
        issue(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, '0, '1);
        issue(1'b0, '0, 1'b1, 1'b0, 16'h00FF, '0, '1);

`ifdef MEMORY_BYTE_WRITE_EN
        issue(1'b0, '0, 1'b1, 1'b1, 16'h0020, 16'hFFFF, 2'b11);
        issue(1'b0, '0, 1'b1, 1'b1, 16'h0020, 16'h0000, 2'b01);
        issue(1'b0, '0, 1'b1, 1'b1, 16'h0020, 16'h1111, 2'b00);
        issue(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0020, '0, 2'b00);
        issue(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0020, 16'h0077, 2'b01);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            issue(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rand_addr(), DW'($urandom()),
                  LANES'($urandom_range(0, (1 << LANES) - 1)));
        end
        idle();

        // Reset mid-clear with a fetch pending: nothing accepted, full clear again.
        rst_n = 1'b0;
        model_reset();
        idle();
        rst_n = 1'b1;
        for (int n = 0; n < 100; n++) issue(1'b1, 16'h000F, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        model_reset();
        issue(1'b1, 16'h000F, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        clear_with_requests();
        issue(1'b1, 16'h000F, 1'b1, 1'b0, 16'h0005, '0, '1);

        // Reset mid-run right after an accepted request: next strobes squashed.
        issue(1'b0, '0, 1'b1, 1'b1, 16'h0003, 16'hC0DE, '1);
        issue(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0003, '0, '1);
        rst_n = 1'b0;
        model_reset();
        issue(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0003, '0, '1);
        rst_n = 1'b1;
        clear_with_requests();
        issue(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0003, '0, '1);

        idle();
        idle();
        check("i_q drained", i_q.size(), 32'd0);
        check("d_q drained", d_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
